// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM arbiter: fixed-latency video fetch over a stalled Z80 handshake
// Video owns the slot whenever it strobes; the CPU is served from C_WAIT otherwise.
module vram_arbiter #(
  parameter int AW     = 14,
  parameter int DW     = 8,
  parameter int STALLW = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [AW-1:0]     vid_a,
  output logic [DW-1:0]     vid_do,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_a,
  input  logic [DW-1:0]     cpu_di,
  output logic [DW-1:0]     cpu_do,
  output logic              cpu_ack,
  output logic [AW-1:0]     mem_a,
  output logic              mem_we,
  output logic [DW-1:0]     mem_di,
  input  logic [DW-1:0]     mem_do,
  output logic [STALLW-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    C_IDLE,
    C_WAIT,
    C_READ,
    C_ACK,
    C_HOLD
  } cpu_state_t;

  cpu_state_t        state_q, state_d;
  logic              vid_p1_q;
  logic              vid_valid_q;
  logic [DW-1:0]     vid_do_q;
  logic [DW-1:0]     cpu_do_q;
  logic [STALLW-1:0] stall_q, stall_d;
  logic              cpu_slot;

  // A request dropped while waiting must not touch the RAM, hence cpu_req in the grant.
  assign cpu_slot = (state_q == C_WAIT) && cpu_req && !vid_req;

  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_di = '0;
    if (vid_req) begin
      mem_a = vid_a;
    end else if (cpu_slot) begin
      mem_a  = cpu_a;
      mem_we = cpu_we;
      mem_di = cpu_di;
    end
  end

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    unique case (state_q)
      C_IDLE: if (cpu_req) state_d = C_WAIT;
      C_WAIT: begin
        if (!cpu_req) begin
          state_d = C_IDLE;
        end else if (vid_req) begin
          if (stall_q != {STALLW{1'b1}}) stall_d = stall_q + STALLW'(1);
        end else begin
          state_d = cpu_we ? C_ACK : C_READ;
        end
      end
      C_READ: state_d = C_ACK;
      C_ACK:  state_d = C_HOLD;
      C_HOLD: if (!cpu_req) state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= C_IDLE;
      stall_q     <= '0;
      vid_p1_q    <= 1'b0;
      vid_valid_q <= 1'b0;
      vid_do_q    <= '0;
      cpu_do_q    <= '0;
    end else begin
      state_q     <= state_d;
      stall_q     <= stall_d;
      vid_p1_q    <= vid_req;
      vid_valid_q <= vid_p1_q;
      if (vid_p1_q) vid_do_q <= mem_do;
      if (state_q == C_READ) cpu_do_q <= mem_do;
    end
  end

  assign vid_do    = vid_do_q;
  assign vid_valid = vid_valid_q;
  assign cpu_do    = cpu_do_q;
  assign cpu_ack   = (state_q == C_ACK);
  assign stall_cnt = stall_q;

endmodule
